ycfg_loader: RTL and testbench

- Synchronous writer for the configuration shift chain of a yellow-cell block.
- Takes column-parallel configuration words from a clocked host over a valid/ready stream. Presents each word on the block's chain input and generates one clean confclk strobe per word.
- Captures the bit word leaving the bottom of the chain into a readback stream, so the old configuration can be verified while the new one is loaded.
- Sits between the host/SoC register logic and one yblock (or a vertical stack of blocks sharing one chain).

---
 rtl/ycfg_pkg.sv | 40 ++++
 rtl/ycfg_phase_timer.sv | 31 +++
 rtl/ycfg_loader.sv | 157 +++++++++++++++
 tb/tb_ycfg_loader.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ycfg_pkg.sv
// Shared state encoding, signal-port encodings and sizing helpers for the
// yellow-cell configuration loader.
package ycfg_pkg;

    // Loader FSM state encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_FETCH = 3'd2;
    localparam logic [2:0] ST_SETUP = 3'd3;
    localparam logic [2:0] ST_HIGH  = 3'd4;
    localparam logic [2:0] ST_HOLD  = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    // Three-valued signal-port encodings, reserved for future port drivers
    typedef enum logic [1:0] {
        VEMPTY = 2'b00,
        V0     = 2'b10,
        V1     = 2'b11
    } vsig_e;

    // Strobe counter must hold FRAME_LEN itself: ceil(log2(FRAME_LEN+1))
    function automatic int cnt_width(input int frame_len);
        return $clog2(frame_len + 1);
    endfunction

    // Phase timer holds values 0..max_cyc-1
    function automatic int timer_width(input int max_cyc);
        return (max_cyc > 1) ? $clog2(max_cyc) : 1;
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/ycfg_phase_timer.sv
// Loadable down-counter shared by the timed loader phases; 'last' is high on
// the final cycle of the loaded phase length.
module ycfg_phase_timer
    import ycfg_pkg::*;
#(
    parameter int MAX_CYC = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            load,
    input  logic [timer_width(MAX_CYC)-1:0] load_val,
    output logic                            last
);

    localparam int W = timer_width(MAX_CYC);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign last = (cnt == '0);

endmodule

// File: rtl/ycfg_loader.sv
// Configuration shift-chain writer: streams host words onto cbitout, issues one
// confclk strobe per word and returns the word leaving the chain bottom.
module ycfg_loader
    import ycfg_pkg::*;
#(
    parameter int BLOCKWIDTH = 8,
    parameter int FRAME_LEN  = 24,
    parameter int SETUP_CYC  = 1,
    parameter int HIGH_CYC   = 2,
    parameter int HOLD_CYC   = 1,
    parameter int CLR_CYC    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  clear,
    output logic                  busy,
    output logic                  done,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BLOCKWIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BLOCKWIDTH-1:0] out_data,
    output logic [BLOCKWIDTH-1:0] cbitout,
    input  logic [BLOCKWIDTH-1:0] cbitin,
    output logic                  confclk,
    output logic                  blk_reset
);

    localparam int CW      = cnt_width(FRAME_LEN);
    localparam int MAX_CYC = max4(SETUP_CYC, HIGH_CYC, HOLD_CYC, CLR_CYC);
    localparam int TW      = timer_width(MAX_CYC);

    localparam logic [TW-1:0] SETUP_LD  = TW'(SETUP_CYC - 1);
    localparam logic [TW-1:0] HIGH_LD   = TW'(HIGH_CYC - 1);
    localparam logic [TW-1:0] HOLD_LD   = TW'(HOLD_CYC - 1);
    localparam logic [TW-1:0] CLR_LD    = TW'(CLR_CYC - 1);
    localparam logic [CW-1:0] FRAME_END = CW'(FRAME_LEN);

    logic [2:0]    state;
    logic [2:0]    state_nx;
    logic [CW-1:0] count;
    logic [CW-1:0] count_inc;
    logic          t_load;
    logic [TW-1:0] t_val;
    logic          t_last;
    logic          in_fire;
    logic          out_fire;
    logic          sample_rb;
    logic          out_valid_nx;

    ycfg_phase_timer #(
        .MAX_CYC (MAX_CYC)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (t_load),
        .load_val (t_val),
        .last     (t_last)
    );

    assign in_fire   = (state == ST_FETCH) && in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign count_inc = count + 1'b1;
    // The bottom word is captured on the last setup cycle, before the strobe shifts it out
    assign sample_rb = (state == ST_SETUP) && t_last;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path infers a latch.
        state_nx = state;
        t_load   = 1'b0;
        t_val    = '0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = ST_FETCH;
                end else if (clear) begin
                    state_nx = ST_CLEAR;
                    t_load   = 1'b1;
                    t_val    = CLR_LD;
                end
            end
            ST_CLEAR: if (t_last) state_nx = ST_IDLE;
            ST_FETCH: begin
                if (in_fire) begin
                    state_nx = ST_SETUP;
                    t_load   = 1'b1;
                    t_val    = SETUP_LD;
                end
            end
            ST_SETUP: begin
                if (t_last) begin
                    state_nx = ST_HIGH;
                    t_load   = 1'b1;
                    t_val    = HIGH_LD;
                end
            end
            ST_HIGH: begin
                if (t_last) begin
                    state_nx = ST_HOLD;
                    t_load   = 1'b1;
                    t_val    = HOLD_LD;
                end
            end
            ST_HOLD: begin
                if (t_last) state_nx = (count_inc == FRAME_END) ? ST_DONE : ST_FETCH;
            end
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        out_valid_nx = out_valid;
        if (sample_rb) begin
            out_valid_nx = 1'b1;
        end else if (out_fire) begin
            out_valid_nx = 1'b0;
        end
    end

    // Outputs are registered from the next state so confclk/blk_reset never glitch.
    // in_ready only rises once the readback slot is known empty, so no word is overwritten.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: data registers are reset as well; every output must read 0 out of reset.
            state     <= ST_IDLE;
            count     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            cbitout   <= '0;
            confclk   <= 1'b0;
            blk_reset <= 1'b0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments only.
            state     <= state_nx;
            busy      <= (state_nx != ST_IDLE);
            done      <= (state_nx == ST_DONE);
            confclk   <= (state_nx == ST_HIGH);
            blk_reset <= (state_nx == ST_CLEAR);
            in_ready  <= (state_nx == ST_FETCH) && !out_valid_nx;
            out_valid <= out_valid_nx;
            if (sample_rb) out_data <= cbitin;
            if (in_fire) cbitout <= in_data;
            if ((state == ST_IDLE) && start) begin
                count <= '0;
            end else if ((state == ST_HOLD) && t_last) begin
                count <= count_inc;
            end
        end
    end

endmodule

// File: tb/tb_ycfg_loader.sv
// Directed bench for ycfg_loader: default instance against a 24-deep chain model,
// plus a FRAME_LEN=1 instance with stretched strobe timing.
module tb_ycfg_loader;

    logic       clk = 1'b0;
    logic       reset, start, clear, in_valid, out_ready;
    logic [7:0] in_data;
    logic       busy, done, in_ready, out_valid, confclk, blk_reset;
    logic [7:0] out_data, cbitout, cbitin;

    logic       b_reset, b_start, b_clear, b_in_valid, b_out_ready;
    logic [7:0] b_in_data, b_cbitin;
    logic       b_busy, b_done, b_in_ready, b_out_valid, b_confclk, b_blk_reset;
    logic [7:0] b_out_data, b_cbitout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ycfg_loader dut (
        .clk (clk), .reset (reset), .start (start), .clear (clear),
        .busy (busy), .done (done),
        .in_valid (in_valid), .in_ready (in_ready), .in_data (in_data),
        .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data),
        .cbitout (cbitout), .cbitin (cbitin), .confclk (confclk), .blk_reset (blk_reset)
    );

    ycfg_loader #(
        .FRAME_LEN (1), .SETUP_CYC (3), .HIGH_CYC (1), .HOLD_CYC (2)
    ) dut_b (
        .clk (clk), .reset (b_reset), .start (b_start), .clear (b_clear),
        .busy (b_busy), .done (b_done),
        .in_valid (b_in_valid), .in_ready (b_in_ready), .in_data (b_in_data),
        .out_valid (b_out_valid), .out_ready (b_out_ready), .out_data (b_out_data),
        .cbitout (b_cbitout), .cbitin (b_cbitin), .confclk (b_confclk), .blk_reset (b_blk_reset)
    );

    // Block model: 24-deep shift chain, shifts on the rising strobe
    logic [7:0] chain [24];
    logic       model_load = 1'b0;

    always @(posedge confclk or posedge model_load) begin
        if (model_load) begin
            for (int i = 0; i < 24; i++) chain[i] <= 8'hA0 + 8'(i);
        end else begin
            for (int i = 23; i > 0; i--) chain[i] <= chain[i-1];
            chain[0] <= cbitout;
        end
    end
    assign cbitin = chain[23];

    // Monitor on the falling edge, away from the active edge
    int   cyc = 0;
    logic cc_prev = 1'b0;
    int   hi_cnt = 0;
    int   rise_cyc[$], fall_cyc[$], widths[$], done_cyc[$];
    logic [7:0] rise_word[$], rb_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (confclk && !cc_prev) begin
            rise_cyc.push_back(cyc);
            rise_word.push_back(cbitout);
        end
        if (!confclk && cc_prev) begin
            fall_cyc.push_back(cyc);
            widths.push_back(hi_cnt);
        end
        hi_cnt  <= confclk ? hi_cnt + 1 : 0;
        if (done) done_cyc.push_back(cyc);
        if (out_valid && out_ready) rb_q.push_back(out_data);
        cc_prev <= confclk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got=running required=finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h required=%0h", name, got, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_done"},      done,      0);
        check({tag, "_in_ready"},  in_ready,  0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"},  out_data,  0);
        check({tag, "_cbitout"},   cbitout,   0);
        check({tag, "_confclk"},   confclk,   0);
        check({tag, "_blk_reset"}, blk_reset, 0);
    endtask

    bit abort = 0;

    task automatic drive_word(input logic [7:0] w, output bit ok);
        in_data  = w;
        in_valid = 1'b1;
        ok       = 1'b0;
        for (int n = 0; n < 200 && !abort; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_frame(input logic [7:0] first, output int n_ok);
        bit ok;
        n_ok = 0;
        for (int k = 0; k < 24; k++) begin
            drive_word(first + 8'(k), ok);
            if (!ok) break;
            n_ok++;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    typedef struct {
        logic [7:0] word;
        logic [7:0] exp_rb;
    } vec_t;

    vec_t vec [24];
    int   r0, f0, d0, rb0, n_ok, my_r, blk_n, busy_n, cb_n, rise_n, fall_n, done_n, hi_n, dn_n;
    bit   ok, hit, seen_rdy, stable;
    logic prev;
    logic [7:0] first_rb;

    initial begin
        // Frame words 0x01..0x18; old chain read back bottom first: 0xB7, 0xB6, ...
        for (int k = 0; k < 24; k++) begin
            vec[k].word   = 8'h01 + 8'(k);
            vec[k].exp_rb = 8'hB7 - 8'(k);
        end

        reset = 1'b1; start = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        b_reset = 1'b1; b_start = 1'b0; b_clear = 1'b0; b_in_valid = 1'b0;
        b_in_data = 8'hFF; b_out_ready = 1'b1; b_cbitin = 8'h5A;
        #1 model_load = 1'b1;
        #1 model_load = 1'b0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        @(posedge clk); #1 reset = 1'b0; b_reset = 1'b0;

        // Full frame with in_valid held and out_ready=1
        r0 = rise_cyc.size(); f0 = fall_cyc.size(); d0 = done_cyc.size(); rb0 = rb_q.size();
        pulse_start();
        drive_frame(8'h01, n_ok);
        wait_done(ok);
        check("frame_done_seen", ok, 1);
        repeat (3) @(negedge clk);
        check("frame_words_taken", n_ok, 24);
        check("frame_strobes", rise_cyc.size() - r0, 24);
        check("frame_readbacks", rb_q.size() - rb0, 24);
        check("frame_done_pulses", done_cyc.size() - d0, 1);
        check("frame_busy_after", busy, 0);
        if (rise_cyc.size() - r0 == 24 && rb_q.size() - rb0 == 24) begin
            for (int k = 0; k < 24; k++) begin
                check($sformatf("frame_cbitout_%0d", k), rise_word[r0+k], vec[k].word);
                check($sformatf("frame_width_%0d", k), widths[f0+k], 2);
                if (k > 0) check($sformatf("frame_period_%0d", k), rise_cyc[r0+k] - rise_cyc[r0+k-1], 5);
                check($sformatf("frame_rb_%0d", k), rb_q[rb0+k], vec[k].exp_rb);
                check($sformatf("frame_chain_%0d", k), chain[23-k], vec[k].word);
            end
            check("frame_done_after_hold", done_cyc[d0] - fall_cyc[f0+23], 1);
        end

        // Readback backpressure: stall after the first readback, then release
        out_ready = 1'b0;
        r0 = rise_cyc.size(); d0 = done_cyc.size(); rb0 = rb_q.size();
        pulse_start();
        fork
            drive_frame(8'h40, n_ok);
            begin
                hit = 1'b0;
                for (int n = 0; n < 50; n++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        hit = 1'b1;
                        break;
                    end
                end
                check("bp_first_rb_valid", hit, 1);
                first_rb = out_data;
                seen_rdy = 1'b0;
                stable   = 1'b1;
                repeat (20) begin
                    @(negedge clk);
                    if (in_ready) seen_rdy = 1'b1;
                    if (out_data != first_rb) stable = 1'b0;
                end
                check("bp_in_ready_low", seen_rdy, 0);
                check("bp_single_strobe", rise_cyc.size() - r0, 1);
                check("bp_out_data", out_data, 8'h01);
                check("bp_out_data_stable", stable, 1);
                check("bp_out_valid_held", out_valid, 1);
                out_ready = 1'b1;
            end
        join
        wait_done(ok);
        check("bp_done_seen", ok, 1);
        repeat (3) @(negedge clk);
        check("bp_words_taken", n_ok, 24);
        check("bp_strobes", rise_cyc.size() - r0, 24);
        check("bp_readbacks", rb_q.size() - rb0, 24);
        check("bp_done_pulses", done_cyc.size() - d0, 1);
        if (rb_q.size() - rb0 == 24) begin
            for (int k = 0; k < 24; k++) check($sformatf("bp_rb_%0d", k), rb_q[rb0+k], vec[k].word);
        end

        // Clear command in IDLE
        r0 = rise_cyc.size();
        @(posedge clk); #1 clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        blk_n = 0; busy_n = 0;
        repeat (10) begin
            @(negedge clk);
            if (blk_reset) blk_n++;
            if (busy) busy_n++;
        end
        check("clr_blk_reset_cycles", blk_n, 4);
        check("clr_busy_cycles", busy_n, 4);
        check("clr_no_strobe", rise_cyc.size() - r0, 0);

        // start and clear together: frame starts, no blk_reset
        @(posedge clk); #1 start = 1'b1; clear = 1'b1;
        @(posedge clk); #1 start = 1'b0; clear = 1'b0;
        @(negedge clk);
        check("sc_busy", busy, 1);
        check("sc_in_ready", in_ready, 1);
        blk_n = 0;
        repeat (4) begin
            if (blk_reset) blk_n++;
            @(negedge clk);
        end
        check("sc_no_blk_reset", blk_n, 0);

        // Asynchronous reset during HIGH of strobe 10 of that frame
        r0 = rise_cyc.size(); d0 = done_cyc.size();
        fork
            drive_frame(8'h80, n_ok);
            begin
                my_r = 0; prev = 1'b0; hit = 1'b0;
                for (int n = 0; n < 400; n++) begin
                    @(negedge clk);
                    if (confclk && !prev) my_r++;
                    prev = confclk;
                    if (my_r == 10) begin
                        hit = 1'b1;
                        break;
                    end
                end
                check("rst_reached_strobe10", hit, 1);
                check("rst_confclk_high_before", confclk, 1);
                #1 reset = 1'b1;
                abort = 1'b1;
                #1;
                check_zero_outputs("async_rst");
                repeat (2) @(posedge clk);
                #1 reset = 1'b0;
            end
        join
        abort = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_idle_busy", busy, 0);
        check("rst_no_done", done_cyc.size() - d0, 0);
        check("rst_strobes_before", rise_cyc.size() - r0, 10);

        // Fresh frame after reset runs all 24 strobes from count 0
        r0 = rise_cyc.size(); d0 = done_cyc.size(); rb0 = rb_q.size();
        pulse_start();
        drive_frame(8'hC0, n_ok);
        wait_done(ok);
        check("reload_done_seen", ok, 1);
        repeat (3) @(negedge clk);
        check("reload_strobes", rise_cyc.size() - r0, 24);
        check("reload_readbacks", rb_q.size() - rb0, 24);
        check("reload_done_pulses", done_cyc.size() - d0, 1);

        // FRAME_LEN=1, SETUP=3, HIGH=1, HOLD=2 instance
        @(posedge clk); #1 b_start = 1'b1; b_in_valid = 1'b1;
        @(posedge clk); #1 b_start = 1'b0;
        cb_n = -1; rise_n = -1; fall_n = -1; done_n = -1; hi_n = 0; dn_n = 0; prev = 1'b0;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            if (b_cbitout == 8'hFF && cb_n < 0) cb_n = n;
            if (b_confclk && !prev) rise_n = n;
            if (!b_confclk && prev) fall_n = n;
            if (b_confclk) hi_n++;
            if (b_done) begin
                dn_n++;
                done_n = n;
            end
            prev = b_confclk;
            if (n == 2) b_in_valid = 1'b0;
        end
        check("b_setup_cycles", rise_n - cb_n, 3);
        check("b_high_cycles", hi_n, 1);
        check("b_fall_after_rise", fall_n - rise_n, 1);
        check("b_done_after_fall", done_n - fall_n, 2);
        check("b_done_pulses", dn_n, 1);
        check("b_cbitout", b_cbitout, 8'hFF);
        check("b_readback", b_out_data, 8'h5A);
        check("b_idle_busy", b_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
